// File: rtl/maxnet_result_memory.sv
// Result memory for the Maxnet datapath: records each per-iteration lane vector,
// detects convergence (single non-zero lane) and offers registered readback.
module maxnet_result_memory #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned LANES  = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [LANES*DATA_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [LANES*DATA_W-1:0]   rd_data,
    output logic [ADDR_W:0]           count,
    output logic                      done,
    output logic                      winner_valid,
    output logic [1:0]                winner_idx,
    output logic [DATA_W-1:0]         winner_val,
    output logic                      no_winner,
    output logic                      full
);

    localparam int unsigned VEC_W = LANES * DATA_W;
    localparam int unsigned NZ_W  = $clog2(LANES + 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    state_t             state;
    logic [VEC_W-1:0]   mem [DEPTH];
    logic [NZ_W-1:0]    nz;
    logic [1:0]         nz_idx;
    logic [DATA_W-1:0]  nz_val;
    logic               accept;
    logic               last_slot;
    logic               rd_hit;

    assign wr_ready  = (state == CAPTURE);
    assign accept    = wr_ready && wr_valid;
    assign last_slot = (count == (ADDR_W+1)'(DEPTH - 1));
    assign rd_hit    = ({1'b0, rd_addr} < count);

    // Count non-zero lanes of the incoming vector and locate the (last) one.
    always_comb begin
        nz     = '0;
        nz_idx = '0;
        nz_val = '0;
        for (int i = 0; i < LANES; i++) begin
            if (wr_data[i*DATA_W +: DATA_W] != '0) begin
                nz     = nz + NZ_W'(1);
                nz_idx = 2'(i);
                nz_val = wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rd_data      <= '0;
            count        <= '0;
            done         <= 1'b0;
            winner_valid <= 1'b0;
            winner_idx   <= '0;
            winner_val   <= '0;
            no_winner    <= 1'b0;
            full         <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // Read-before-write falls out of the non-blocking memory update.
            rd_data <= rd_hit ? mem[rd_addr] : '0;

            if (start) begin
                state        <= CAPTURE;
                count        <= '0;
                done         <= 1'b0;
                winner_valid <= 1'b0;
                winner_idx   <= '0;
                winner_val   <= '0;
                no_winner    <= 1'b0;
                full         <= 1'b0;
            end else if (accept) begin
                mem[count[ADDR_W-1:0]] <= wr_data;
                count                  <= count + (ADDR_W+1)'(1);
                if (nz == NZ_W'(1)) begin
                    state        <= DONE;
                    done         <= 1'b1;
                    winner_valid <= 1'b1;
                    winner_idx   <= nz_idx;
                    winner_val   <= nz_val;
                end else if (nz == '0) begin
                    state     <= DONE;
                    done      <= 1'b1;
                    no_winner <= 1'b1;
                end else if (last_slot) begin
                    state <= DONE;
                    done  <= 1'b1;
                    full  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxnet_result_memory.sv
// Self-checking bench for maxnet_result_memory: directed plan plus random traffic
// compared against a run-level behavioural model.
module tb_maxnet_result_memory;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned LANES  = 4;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    wr_valid;
    logic                    wr_ready;
    logic [LANES*DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0]       rd_addr;
    logic [LANES*DATA_W-1:0] rd_data;
    logic [ADDR_W:0]         count;
    logic                    done;
    logic                    winner_valid;
    logic [1:0]              winner_idx;
    logic [DATA_W-1:0]       winner_val;
    logic                    no_winner;
    logic                    full;

    int checks = 0;
    int errors = 0;

    // Reference state: the run's history and its outcome.
    logic [15:0] m_mem [DEPTH];
    int          m_count;
    bit          m_capturing;
    bit          m_done, m_wv, m_nw, m_full;
    int          m_idx, m_val;

    always #5 clk = ~clk;

    maxnet_result_memory #(
        .DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_data(wr_data), .rd_addr(rd_addr),
        .rd_data(rd_data), .count(count), .done(done),
        .winner_valid(winner_valid), .winner_idx(winner_idx),
        .winner_val(winner_val), .no_winner(no_winner), .full(full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0;
        m_count = 0; m_capturing = 0;
        m_done = 0; m_wv = 0; m_nw = 0; m_full = 0; m_idx = 0; m_val = 0;
    endtask

    // Apply one cycle of stimulus, advance the model, compare every output.
    task automatic step(input bit r, input bit s, input bit v,
                        input logic [15:0] d, input logic [3:0] ra);
        logic [15:0] exp_rd;
        int nzc, lane_idx, lane_val;
        @(negedge clk);
        rst = r; start = s; wr_valid = v; wr_data = d; rd_addr = ra;
        exp_rd = (!r && int'(ra) < m_count) ? m_mem[ra] : 16'h0;
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else if (s) begin
            m_capturing = 1; m_count = 0;
            m_done = 0; m_wv = 0; m_nw = 0; m_full = 0; m_idx = 0; m_val = 0;
        end else if (m_capturing && v) begin
            m_mem[m_count] = d;
            m_count++;
            nzc = 0; lane_idx = 0; lane_val = 0;
            for (int i = 0; i < LANES; i++) begin
                if (((d >> (4*i)) & 16'hF) != 0) begin
                    nzc++; lane_idx = i; lane_val = int'((d >> (4*i)) & 16'hF);
                end
            end
            if (nzc == 1) begin
                m_wv = 1; m_idx = lane_idx; m_val = lane_val;
            end else if (nzc == 0) begin
                m_nw = 1;
            end else if (m_count == DEPTH) begin
                m_full = 1;
            end
            if (m_wv || m_nw || m_full) begin
                m_done = 1; m_capturing = 0;
            end
        end
        check("wr_ready",     32'(wr_ready),     32'(m_capturing));
        check("rd_data",      32'(rd_data),      32'(exp_rd));
        check("count",        32'(count),        32'(m_count));
        check("done",         32'(done),         32'(m_done));
        check("winner_valid", 32'(winner_valid), 32'(m_wv));
        check("winner_idx",   32'(winner_idx),   32'(m_idx));
        check("winner_val",   32'(winner_val),   32'(m_val));
        check("no_winner",    32'(no_winner),    32'(m_nw));
        check("full",         32'(full),         32'(m_full));
    endtask

    function automatic logic [15:0] rand_vec();
        logic [15:0] vv = 16'h0;
        for (int i = 0; i < LANES; i++) begin
            if ($urandom_range(0, 1) == 1) vv[i*4 +: 4] = 4'($urandom_range(1, 15));
        end
        return vv;
    endfunction

    initial begin
        rst = 1'b1; start = 0; wr_valid = 0; wr_data = '0; rd_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        step(1, 0, 0, 16'h0, 4'h0);

        // Converge: winner in lane 2, then read back entry 1.
        step(0, 1, 0, 16'h0, 4'h0);
        step(0, 0, 1, 16'h3521, 4'h0);
        step(0, 0, 1, 16'h0320, 4'h0);
        step(0, 0, 1, 16'h0100, 4'h0);
        check("conv_idx_const", 32'(winner_idx), 32'd2);
        check("conv_val_const", 32'(winner_val), 32'd1);
        step(0, 0, 0, 16'h0, 4'h1);
        check("conv_rd1_const", 32'(rd_data), 32'h0320);

        // All-zero vector, then a write after done is ignored.
        step(0, 1, 0, 16'h0, 4'h0);
        step(0, 0, 1, 16'h0000, 4'h0);
        step(0, 0, 1, 16'h1111, 4'h0);
        check("zero_count_const", 32'(count), 32'd1);

        // Full without convergence.
        step(0, 1, 0, 16'h0, 4'h0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 16'h1111, 4'(i));
        check("full_const", 32'(full), 32'd1);
        step(0, 0, 0, 16'h0, 4'hF);

        // Convergence in the last slot beats full.
        step(0, 1, 0, 16'h0, 4'h0);
        for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 1, 16'h1111, 4'h0);
        step(0, 0, 1, 16'h0800, 4'h0);
        check("last_wv_const", 32'(winner_valid), 32'd1);

        // Backpressure gaps; rd_addr 5 beyond count returns 0.
        step(0, 1, 0, 16'h0, 4'h0);
        step(0, 0, 0, 16'hFFFF, 4'h0);
        step(0, 0, 1, 16'h2211, 4'h0);
        step(0, 0, 0, 16'hAAAA, 4'h0);
        step(0, 0, 1, 16'h0210, 4'h0);
        step(0, 0, 0, 16'h5555, 4'h5);
        step(0, 0, 1, 16'h0010, 4'h1);
        step(0, 0, 0, 16'h0, 4'h5);

        // Restart mid-run drops the concurrent vector; reset clears everything.
        step(0, 1, 0, 16'h0, 4'h0);
        step(0, 0, 1, 16'h3300, 4'h0);
        step(0, 1, 1, 16'h4444, 4'h0);
        step(0, 0, 1, 16'h3300, 4'h0);
        step(1, 0, 0, 16'h0, 4'h0);
        step(0, 0, 1, 16'h0100, 4'h0);
        step(0, 0, 0, 16'h0, 4'h0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 2) != 0),
                 rand_vec(), 4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
